// File: rtl/tone_sequencer_voice.sv
// Single-voice square-wave tone generator: one note/rest request at a time over valid/ready.
// Optional one-entry legato request buffer enabled by defining TONE_LEGATO_EN.
module tone_sequencer_voice #(
  parameter int CLK_HZ = 12000000,
  parameter int CNT_W  = 24,
  parameter int DUR_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [3:0]       note,
  input  logic [2:0]       octave,
  input  logic [DUR_W-1:0] duration,
  output logic             square_wave,
  output logic             busy,
  output logic             done
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t r_state, w_state_next;

  // Octave-4 half-period in clocks; semitones 12..15 are rests and return 0.
  function automatic logic [CNT_W-1:0] base_half(input logic [3:0] n);
    logic [63:0] fc;
    case (n)
      4'd0:    fc = 64'd26163;
      4'd1:    fc = 64'd27718;
      4'd2:    fc = 64'd29366;
      4'd3:    fc = 64'd31113;
      4'd4:    fc = 64'd32963;
      4'd5:    fc = 64'd34923;
      4'd6:    fc = 64'd36999;
      4'd7:    fc = 64'd39200;
      4'd8:    fc = 64'd41530;
      4'd9:    fc = 64'd44000;
      4'd10:   fc = 64'd46616;
      4'd11:   fc = 64'd49388;
      default: fc = 64'd0;
    endcase
    if (fc == 64'd0) return '0;
    return CNT_W'((64'(CLK_HZ) * 64'd50) / fc);
  endfunction

  logic [CNT_W-1:0] r_half, r_phase;
  logic             r_rest;
  logic [DUR_W-1:0] r_remain;
  logic [PS_W-1:0]  r_presc;
  logic             r_square;
  logic             r_done;

  logic [CNT_W-1:0] w_base, w_half;
  logic             w_playing, w_tick, w_end, w_wrap;
  logic             w_accept, w_in_rest, w_in_zero;
  logic             w_load, w_load_rest, w_done_set;
  logic [CNT_W-1:0] w_load_half;
  logic [DUR_W-1:0] w_load_dur;

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    w_base = base_half(note);
    if (octave < 3'd4) w_half = w_base << (3'd4 - octave);
    else               w_half = w_base >> (octave - 3'd4);
  end

  assign w_playing = (r_state == S_PLAY);
  assign w_tick    = w_playing && (r_presc == PS_LAST);
  assign w_end     = w_tick && (r_remain == DUR_W'(1));
  assign w_wrap    = w_playing && !r_rest && (r_phase == r_half - CNT_W'(1));
  assign w_accept  = note_valid && note_ready;
  assign w_in_rest = (note >= 4'd12);
  assign w_in_zero = (duration == '0);

`ifdef TONE_LEGATO_EN
  logic             r_buf_valid;
  logic [CNT_W-1:0] r_buf_half;
  logic             r_buf_rest;
  logic [DUR_W-1:0] r_buf_dur;
  logic [1:0]       r_done_pend;
  logic             w_direct, w_to_buf, w_skip;
  logic [2:0]       w_done_cnt;

  assign note_ready = !r_buf_valid;
  // A request arriving on the end edge bypasses the buffer and starts directly.
  assign w_direct   = w_accept && (!w_playing || w_end);
  assign w_to_buf   = w_accept && w_playing && !w_end;
  assign w_skip     = w_end && r_buf_valid && (r_buf_dur == '0);

  always_comb begin
    w_load      = 1'b0;
    w_load_half = w_half;
    w_load_rest = w_in_rest;
    w_load_dur  = duration;
    if (w_end && r_buf_valid && (r_buf_dur != '0)) begin
      w_load      = 1'b1;
      w_load_half = r_buf_half;
      w_load_rest = r_buf_rest;
      w_load_dur  = r_buf_dur;
    end else if (w_direct && !w_in_zero) begin
      w_load = 1'b1;
    end
    // Coincident completions are serialised so every request gets its own done pulse.
    w_done_cnt = 3'(w_end) + 3'(w_direct && w_in_zero) + 3'(w_skip) + 3'(r_done_pend);
    w_done_set = (w_done_cnt != 3'd0);
  end

  // NOTE: the buffer is a handful of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_half  <= '0;
      r_buf_rest  <= 1'b0;
      r_buf_dur   <= '0;
      r_done_pend <= '0;
    end else begin
      if (w_to_buf) begin
        r_buf_valid <= 1'b1;
        r_buf_half  <= w_half;
        r_buf_rest  <= w_in_rest;
        r_buf_dur   <= duration;
      end else if (w_end && r_buf_valid) begin
        r_buf_valid <= 1'b0;
      end
      r_done_pend <= (w_done_cnt == 3'd0) ? 2'd0 : 2'(w_done_cnt - 3'd1);
    end
  end
`else
  assign note_ready = (r_state == S_IDLE);

  always_comb begin
    w_load      = w_accept && !w_in_zero;
    w_load_half = w_half;
    w_load_rest = w_in_rest;
    w_load_dur  = duration;
    w_done_set  = w_end || (w_accept && w_in_zero);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: if (w_load) w_state_next = S_PLAY;
      S_PLAY: begin
        busy = 1'b1;
        if (w_end && !w_load) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half   <= '0;
      r_phase  <= '0;
      r_rest   <= 1'b0;
      r_remain <= '0;
      r_presc  <= '0;
      r_square <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_load) begin
        r_half   <= w_load_half;
        r_rest   <= w_load_rest;
        r_remain <= w_load_dur;
        r_phase  <= '0;
        r_presc  <= '0;
        r_square <= 1'b0;
      end else if (w_end) begin
        // End of duration overrides a coincident toggle.
        r_square <= 1'b0;
        r_phase  <= '0;
        r_presc  <= '0;
        r_remain <= '0;
      end else if (w_playing) begin
        if (w_tick) begin
          r_presc  <= '0;
          r_remain <= r_remain - DUR_W'(1);
        end else begin
          r_presc <= r_presc + PS_W'(1);
        end
        if (w_wrap) begin
          r_phase  <= '0;
          r_square <= ~r_square;
        end else if (!r_rest) begin
          r_phase <= r_phase + CNT_W'(1);
        end
      end
    end
  end

  assign square_wave = r_square;
  assign done        = r_done;

endmodule

// File: tb/tb_tone_sequencer_voice.sv
// Self-checking bench for tone_sequencer_voice (default build, no legato buffer).
// A scaled 120 kHz clock keeps every note short; expected waveforms come from the pitch formula.
module tb_tone_sequencer_voice;

  localparam int CLK_HZ = 120000;
  localparam int DUR_W  = 16;
  localparam int MS     = CLK_HZ / 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             note_valid;
  logic             note_ready;
  logic [3:0]       note;
  logic [2:0]       octave;
  logic [DUR_W-1:0] duration;
  logic             square_wave;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  tone_sequencer_voice #(.CLK_HZ(CLK_HZ), .CNT_W(24), .DUR_W(DUR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note       (note),
    .octave     (octave),
    .duration   (duration),
    .square_wave(square_wave),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Half-period in clocks from the centi-Hz pitch table and the octave shift rule.
  function automatic int half_ref(input int n, input int o);
    int fc [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                    36999, 39200, 41530, 44000, 46616, 49388};
    int b;
    if (n >= 12) return 0;
    b = (CLK_HZ * 50) / fc[n];
    if (o < 4) return b << (4 - o);
    return b >> (o - 4);
  endfunction

  // Called 1 time unit after the accept edge; walks the expected note timeline cycle by cycle.
  task automatic follow(input int n, input int o, input int d, input int limit);
    int half, endk, last, exp_sq;
    half = half_ref(n, o);
    endk = d * MS;
    if (d == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_ready", note_ready, 1);
      check("zero_sq", square_wave, 0);
      @(posedge clk); #1;
      check("zero_done_drop", done, 0);
      return;
    end
    check("acc_sq", square_wave, 0);
    check("acc_busy", busy, 1);
    check("acc_ready", note_ready, 0);
    check("acc_done", done, 0);
    last = (limit < endk) ? limit : endk;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (k < endk) begin
        exp_sq = (half == 0) ? 0 : ((k / half) % 2);
        check("play_sq", square_wave, exp_sq);
        check("play_busy", busy, 1);
        check("play_done", done, 0);
        check("play_ready", note_ready, 0);
      end else begin
        check("end_sq", square_wave, 0);
        check("end_busy", busy, 0);
        check("end_done", done, 1);
        check("end_ready", note_ready, 1);
      end
    end
  endtask

  task automatic present(input int n, input int o, input int d);
    note_valid = 1'b1;
    note       = 4'(n);
    octave     = 3'(o);
    duration   = DUR_W'(d);
  endtask

  task automatic issue(input int n, input int o, input int d);
    check("ready_before", note_ready, 1);
    present(n, o, d);
    @(posedge clk); #1;
    note_valid = 1'b0;
    follow(n, o, d, d * MS);
  endtask

  initial begin
    int n, o, d, pulses;
    rst        = 1'b1;
    note_valid = 1'b0;
    note       = '0;
    octave     = '0;
    duration   = '0;
    #1;
    check("rst_sq", square_wave, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", note_ready, 1);
    check("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // A4 for 2 ms, then C6 and C0 (long enough to see the first C0 toggle), then a rest.
    issue(9, 4, 2);
    issue(0, 6, 1);
    issue(0, 0, 40);
    issue(12, 3, 1);
    issue(0, 4, 0);

    // Request held through a note: taken only on the edge after note_ready returns.
    present(9, 4, 1);
    @(posedge clk); #1;
    present(2, 5, 1);
    follow(9, 4, 1, MS);
    @(posedge clk); #1;
    note_valid = 1'b0;
    follow(2, 5, 1, MS);

    // Asynchronous reset while A4 output is high aborts without a done pulse.
    present(9, 4, 2);
    @(posedge clk); #1;
    note_valid = 1'b0;
    follow(9, 4, 2, 200);
    #3 rst = 1'b1;
    #1;
    check("abort_sq", square_wave, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", note_ready, 1);
    check("abort_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_idle", busy, 0);

    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(0, 15);
      o = $urandom_range(0, 7);
      d = $urandom_range(0, 3);
      issue(n, o, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_sequencer_voice.md
Name: tone_sequencer_voice

Overview:
- Parametrised successor to the fixed 8-note square-wave generator.
- Plays one note request at a time over a valid/ready handshake: 12 semitones x 8 octaves plus rest, for a programmed duration in milliseconds.
- Signals completion and returns the square wave low when the note ends.
- Sits between the melody sequencer (note source) and the speaker/PWM pin.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz; sets pitch table and ms tick.
- CNT_W, 24, width of the half-period counter; must hold the octave-0 C half-period.
- DUR_W, 16, width of the duration field, in ms.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- note_valid  in  1  request present.
- note_ready  out  1  block can accept a request.
- note  in  4  0..11 = C..B semitone; 12..15 = rest (silence).
- octave  in  3  0..7; octave 4 is the reference octave (A4 = 440 Hz).
- duration  in  DUR_W  note length in ms.
- square_wave  out  1  tone output.
- busy  out  1  high while a note or rest is playing.
- done  out  1  one-cycle pulse at end of note.

Behaviour:
- Reset (async, immediate): square_wave=0, busy=0, done=0, note_ready=1, all counters 0, state IDLE. Reset mid-note aborts the note with no done pulse.
- Base half-periods, octave 4: BASE[n] = (CLK_HZ*50)/FC[n], integer truncation, where FC is in centi-Hz: 26163 27718 29366 31113 32963 34923 36999 39200 41530 44000 46616 49388. For 12 MHz: C4 = 22933, A4 = 13636.
- Octave scaling: HALF = BASE << (4-octave) for octave<4; HALF = BASE >> (octave-4) for octave>4. Computed once at accept and latched.
- ms tick: prescaler counts 0..CLK_HZ/1000-1 and produces one tick per wrap.
- States:
  - IDLE: note_ready=1, busy=0.
  - PLAY: note_ready=0, busy=1.
- Accept on the rising edge where note_valid && note_ready.
  - If duration==0: stay in IDLE, pulse done on the next cycle, square_wave unchanged at 0.
  - Otherwise: latch HALF, rest flag and duration; clear phase counter and prescaler; square_wave=0; enter PLAY.
- PLAY tone:
  - Phase counter counts 0..HALF-1.
  - On wrap, square_wave toggles, so the output period is exactly 2*HALF clocks.
  - First toggle occurs HALF cycles after the accept edge.
- PLAY rest: square_wave held 0; phase counter idle.
- Duration: remaining ms decrements on each tick. On the tick that reaches 0 (accept edge + duration*CLK_HZ/1000 cycles):
  - square_wave forced 0, done=1 for one cycle, state to IDLE.
  - note_ready is high from that same edge.
- If a toggle and end-of-duration coincide, end-of-duration wins and the output goes 0.
- note_valid while not ready is ignored. Inputs need not be held after accept.

Optional Feature:
- Macro TONE_LEGATO_EN.
- When defined:
  - One-entry request buffer. note_ready = buffer empty, so requests are accepted during PLAY.
  - At end of duration with buffer full: done still pulses, the buffered note loads on the same edge, and PLAY continues with no IDLE cycle. Phase counter and prescaler clear; square_wave restarts at 0.
  - A buffered duration==0 request produces a done pulse and is skipped.
  - Reset clears the buffer.
- When not defined: no buffer; note_ready=1 only in IDLE, exactly as specified above.

Test Plan:
1. Reset behaviour: rst asserted mid-PLAY of A4 -> same cycle square_wave=0, busy=0, note_ready=1; no done pulse.
2. A4 tone: note=9, octave=4, duration=2 -> toggles at +13636 cycles; done at +24000, square_wave=0, busy falls, note_ready=1.
3. Octave shift: note=0, octave=6, duration=1 -> half-period 5733 cycles (period 11466). Then octave=0 -> half-period 366928.
4. Rest: note=12, duration=1 -> square_wave stays 0 for 12000 cycles, busy=1, then done pulse.
5. Zero duration: duration=0 -> busy never rises, done pulses one cycle after accept. A request held while busy is not accepted until note_ready.
6. Legato (TONE_LEGATO_EN): second request during PLAY is accepted immediately -> on first done, second note starts the same cycle, busy never drops, two done pulses total.
